// File: rtl/alu_share_arb_if.sv
// Request/response bundle for the two requesters sharing one ALU.
interface alu_share_arb_if #(
   parameter int unsigned REG_WIDTH = 32,
   parameter int unsigned FUNC_SIZE = 4,
   parameter int unsigned FLAGN     = 3
);
   logic                 req_valid_0;
   logic                 req_valid_1;
   logic                 req_ready_0;
   logic                 req_ready_1;
   logic [FUNC_SIZE-1:0] req_func_0;
   logic [FUNC_SIZE-1:0] req_func_1;
   logic [REG_WIDTH-1:0] req_in1_0;
   logic [REG_WIDTH-1:0] req_in1_1;
   logic [REG_WIDTH-1:0] req_in2_0;
   logic [REG_WIDTH-1:0] req_in2_1;
   logic                 rsp_valid_0;
   logic                 rsp_valid_1;
   logic                 rsp_ready_0;
   logic                 rsp_ready_1;
   logic [REG_WIDTH-1:0] rsp_result_0;
   logic [REG_WIDTH-1:0] rsp_result_1;
   logic [FLAGN-1:0]     rsp_flag_0;
   logic [FLAGN-1:0]     rsp_flag_1;

   // Requester side
   modport master (
      output req_valid_0, req_valid_1, req_func_0, req_func_1,
             req_in1_0, req_in1_1, req_in2_0, req_in2_1,
             rsp_ready_0, rsp_ready_1,
      input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
             rsp_result_0, rsp_result_1, rsp_flag_0, rsp_flag_1
   );

   // Arbiter side
   modport slave (
      input  req_valid_0, req_valid_1, req_func_0, req_func_1,
             req_in1_0, req_in1_1, req_in2_0, req_in2_1,
             rsp_ready_0, rsp_ready_1,
      output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
             rsp_result_0, rsp_result_1, rsp_flag_0, rsp_flag_1
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one RV32I ALU between two valid/ready requesters,
// with a registered response slot per port.
module alu_share_arb #(
   parameter int unsigned REG_WIDTH = 32,
   parameter int unsigned FUNC_SIZE = 4,
   parameter int unsigned FLAGN     = 3
) (
   input logic            clk,
   input logic            rst_n,
   alu_share_arb_if.slave bus
);
   localparam int unsigned SHAMT_W = $clog2(REG_WIDTH);

   localparam logic [FUNC_SIZE-1:0] FN_ADD  = FUNC_SIZE'(4'b0000);
   localparam logic [FUNC_SIZE-1:0] FN_SUB  = FUNC_SIZE'(4'b1000);
   localparam logic [FUNC_SIZE-1:0] FN_SLL  = FUNC_SIZE'(4'b0001);
   localparam logic [FUNC_SIZE-1:0] FN_SLT  = FUNC_SIZE'(4'b0010);
   localparam logic [FUNC_SIZE-1:0] FN_SLTU = FUNC_SIZE'(4'b0011);
   localparam logic [FUNC_SIZE-1:0] FN_XOR  = FUNC_SIZE'(4'b0100);
   localparam logic [FUNC_SIZE-1:0] FN_SRL  = FUNC_SIZE'(4'b0101);
   localparam logic [FUNC_SIZE-1:0] FN_SRA  = FUNC_SIZE'(4'b1101);
   localparam logic [FUNC_SIZE-1:0] FN_OR   = FUNC_SIZE'(4'b0110);
   localparam logic [FUNC_SIZE-1:0] FN_AND  = FUNC_SIZE'(4'b0111);

   logic                 cand_0, cand_1;
   logic                 grant_0, grant_1;
   logic                 last_grant;      // 1: port 1 won the last grant

   logic [FUNC_SIZE-1:0] op_func;
   logic [REG_WIDTH-1:0] op_in1, op_in2;
   logic [SHAMT_W-1:0]   shamt;
   logic                 eq, ltu, lt;
   logic [REG_WIDTH-1:0] alu_result;
   logic [FLAGN-1:0]     alu_flag;

   logic                 valid_0, valid_1;
   logic [REG_WIDTH-1:0] result_0, result_1;
   logic [FLAGN-1:0]     flag_0, flag_1;

   // Eligibility and round-robin grant; nothing is granted while in reset
   always_comb begin
      cand_0  = bus.req_valid_0 && (!valid_0 || bus.rsp_ready_0);
      cand_1  = bus.req_valid_1 && (!valid_1 || bus.rsp_ready_1);
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      if (rst_n) begin
         if (cand_0 && cand_1) begin
            grant_0 = last_grant;
            grant_1 = !last_grant;
         end else begin
            grant_0 = cand_0;
            grant_1 = cand_1;
         end
      end
   end

   // Operand mux; defaults to port 0 when idle
   always_comb begin
      op_func = grant_1 ? bus.req_func_1 : bus.req_func_0;
      op_in1  = grant_1 ? bus.req_in1_1  : bus.req_in1_0;
      op_in2  = grant_1 ? bus.req_in2_1  : bus.req_in2_0;
   end

   // Shared ALU: result by function code, flags always from the operands
   always_comb begin
      alu_result = '0;
      shamt      = op_in2[SHAMT_W-1:0];
      eq         = (op_in1 == op_in2);
      ltu        = (op_in1 < op_in2);
      lt         = ($signed(op_in1) < $signed(op_in2));
      alu_flag   = FLAGN'({eq, ltu, lt});
      case (op_func)
         FN_ADD:  alu_result = op_in1 + op_in2;
         FN_SUB:  alu_result = op_in1 - op_in2;
         FN_SLL:  alu_result = op_in1 << shamt;
         FN_SLT:  alu_result = REG_WIDTH'(lt);
         FN_SLTU: alu_result = REG_WIDTH'(ltu);
         FN_XOR:  alu_result = op_in1 ^ op_in2;
         FN_SRL:  alu_result = op_in1 >> shamt;
         FN_SRA:  alu_result = REG_WIDTH'($signed(op_in1) >>> shamt);
         FN_OR:   alu_result = op_in1 | op_in2;
         FN_AND:  alu_result = op_in1 & op_in2;
         default: alu_result = '0;
      endcase
   end

   // Response slots and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_0    <= 1'b0;
         valid_1    <= 1'b0;
         result_0   <= '0;
         result_1   <= '0;
         flag_0     <= '0;
         flag_1     <= '0;
         last_grant <= 1'b1;
      end else begin
         if (grant_0) begin
            valid_0  <= 1'b1;
            result_0 <= alu_result;
            flag_0   <= alu_flag;
         end else if (bus.rsp_ready_0) begin
            valid_0  <= 1'b0;
         end
         if (grant_1) begin
            valid_1  <= 1'b1;
            result_1 <= alu_result;
            flag_1   <= alu_flag;
         end else if (bus.rsp_ready_1) begin
            valid_1  <= 1'b0;
         end
         if (grant_0) begin
            last_grant <= 1'b0;
         end else if (grant_1) begin
            last_grant <= 1'b1;
         end
      end
   end

   assign bus.req_ready_0  = grant_0;
   assign bus.req_ready_1  = grant_1;
   assign bus.rsp_valid_0  = valid_0;
   assign bus.rsp_valid_1  = valid_1;
   assign bus.rsp_result_0 = result_0;
   assign bus.rsp_result_1 = result_1;
   assign bus.rsp_flag_0   = flag_0;
   assign bus.rsp_flag_1   = flag_1;
endmodule
